cpu_ctrl: RTL and testbench

Multi-cycle control unit for the 16-bit, four-register CPU: sequences instruction fetch from the synchronous instruction ROM, decode, execute and register write-back, and drives the datapath's register-select, ALU and write-enable controls. Sits inside the CPU core between the instruction ROM and the datapath/register group, replacing ad-hoc single-cycle control. Also owns the PC, the halt state and a retired-instruction counter for bench observability.

---
 rtl/cpu_ctrl_pkg.sv | 45 ++++
 rtl/cpu_ctrl_decode.sv | 56 +++++
 rtl/cpu_ctrl.sv | 110 +++++++++++
 tb/tb_cpu_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode map, ALU codes, FSM states and instruction layout for the
// multi-cycle CPU control unit.
package cpu_ctrl_pkg;

    localparam int unsigned AWIDTH_DEF = 12;
    localparam int unsigned DWIDTH_DEF = 16;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned OPC_W      = 4;
    localparam int unsigned RSEL_W     = 2;
    localparam int unsigned IMM_W      = 8;
    localparam int unsigned ALUOP_W    = 2;
    localparam int unsigned RET_W      = 16;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h4;
    localparam logic [OPC_W-1:0] OP_ANDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OPC_W-1:0] OP_BNZ  = 4'h9;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [RSEL_W-1:0] rd;
        logic [RSEL_W-1:0] rs;
        logic [IMM_W-1:0]  imm;
    } instr_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decode into ALU controls and instruction class flags.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_src_imm,
    output logic               writes_rd,
    output logic               is_jmp,
    output logic               is_bnz,
    output logic               is_halt
);

    // Unlisted opcodes fall through as NOPs with all flags low.
    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        writes_rd   = 1'b0;
        is_jmp      = 1'b0;
        is_bnz      = 1'b0;
        is_halt     = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_op    = ALU_ADD;
                writes_rd = 1'b1;
            end
            OP_SUB: begin
                alu_op    = ALU_SUB;
                writes_rd = 1'b1;
            end
            OP_AND: begin
                alu_op    = ALU_AND;
                writes_rd = 1'b1;
            end
            OP_OR: begin
                alu_op    = ALU_OR;
                writes_rd = 1'b1;
            end
            OP_ADDI: begin
                alu_op      = ALU_ADD;
                alu_src_imm = 1'b1;
                writes_rd   = 1'b1;
            end
            OP_ANDI: begin
                alu_op      = ALU_AND;
                alu_src_imm = 1'b1;
                writes_rd   = 1'b1;
            end
            OP_JMP:  is_jmp  = 1'b1;
            OP_BNZ:  is_bnz  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/WB sequencing, PC, IR, halt
// state and retired-instruction counter for the four-register CPU.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH = AWIDTH_DEF,
    parameter int unsigned DWIDTH = DWIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_in,
    input  logic [DWIDTH-1:0]   instr,
    input  logic                rd_zero,
    output logic                rom_en,
    output logic [AWIDTH-1:0]   pc,
    output logic [RSEL_W-1:0]   rd_sel,
    output logic [RSEL_W-1:0]   rs_sel,
    output logic [IMM_W-1:0]    imm,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                alu_src_imm,
    output logic                rf_we,
    output logic                halted,
    output logic [RET_W-1:0]    retired
);

    state_t            state;
    state_t            next_state;
    logic [DWIDTH-1:0] ir;
    instr_t            ir_f;
    logic              taken;
    logic              writes_rd;
    logic              is_jmp;
    logic              is_bnz;
    logic              is_halt;

    assign ir_f   = instr_t'(ir[INSTR_W-1:0]);
    assign rd_sel = ir_f.rd;
    assign rs_sel = ir_f.rs;
    assign imm    = ir_f.imm;
    assign halted = (state == S_HALT);

    cpu_ctrl_decode u_decode (
        .opcode      (ir_f.opcode),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .writes_rd   (writes_rd),
        .is_jmp      (is_jmp),
        .is_bnz      (is_bnz),
        .is_halt     (is_halt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobes are gated by rst so an instruction caught by reset never writes.
    always_comb begin
        next_state = state;
        rom_en     = 1'b0;
        rf_we      = 1'b0;
        if (en_in && !rst) begin
            case (state)
                S_IDLE:   next_state = S_FETCH;
                S_FETCH: begin
                    rom_en     = 1'b1;
                    next_state = S_DECODE;
                end
                S_DECODE: next_state = S_EXEC;
                S_EXEC:   next_state = S_WB;
                S_WB: begin
                    rf_we      = writes_rd;
                    next_state = is_halt ? S_HALT : S_FETCH;
                end
                S_HALT:   next_state = S_HALT;
                default:  next_state = S_IDLE;
            endcase
        end
    end

    // PC, IR, branch flag and retire counter only move while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            ir      <= '0;
            retired <= '0;
            taken   <= 1'b0;
        end else if (en_in) begin
            case (state)
                S_DECODE: ir    <= instr;
                S_EXEC:   taken <= !rd_zero;
                S_WB: begin
                    retired <= retired + RET_W'(1);
                    if (!is_halt) begin
                        if (is_jmp || (is_bnz && taken)) begin
                            pc <= AWIDTH'(ir_f.imm);
                        end else begin
                            pc <= pc + AWIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: emulates ROM and register file around the controller and
// checks against hand tables and an instruction-level reference interpreter.
module tb_cpu_ctrl;

    logic        clk;
    logic        rst;
    logic        en_in;
    logic [15:0] instr;
    logic        rd_zero;
    logic        rom_en;
    logic [11:0] pc;
    logic [1:0]  rd_sel;
    logic [1:0]  rs_sel;
    logic [7:0]  imm;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic        rf_we;
    logic        halted;
    logic [15:0] retired;

    cpu_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en_in       (en_in),
        .instr       (instr),
        .rd_zero     (rd_zero),
        .rom_en      (rom_en),
        .pc          (pc),
        .rd_sel      (rd_sel),
        .rs_sel      (rs_sel),
        .imm         (imm),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .rf_we       (rf_we),
        .halted      (halted),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rom [4096];
    logic [15:0] regs [4];
    int          n_cmp;
    int          n_bad;
    int          we_cnt;
    int          en_cnt;

    // Reference interpreter state
    logic [15:0] mregs [4];
    logic [11:0] mpc;
    logic [15:0] mret;
    logic        mhalt;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] rd_init;
        logic [15:0] rs_init;
        logic [11:0] exp_pc;
        logic [15:0] exp_rd;
        int          exp_we;
        logic        exp_halt;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] alu_result();
        logic [15:0] a;
        logic [15:0] b;
        a = regs[rd_sel];
        b = alu_src_imm ? {8'h00, imm} : regs[rs_sel];
        case (alu_op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    // One clock of the ROM + register-file environment.
    task automatic step();
        logic        do_rd;
        logic        do_we;
        logic [11:0] a;
        logic [1:0]  d;
        logic [15:0] res;
        #1;
        rd_zero = (regs[rd_sel] == 16'd0);
        #1;
        do_rd = rom_en;
        a     = pc;
        do_we = rf_we;
        d     = rd_sel;
        res   = alu_result();
        if (en_in) en_cnt++;
        @(posedge clk);
        #1;
        if (do_rd) instr = rom[a];
        if (do_we) begin
            regs[d] = res;
            we_cnt++;
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en_in = 1'b0;
        step();
        step();
        rst    = 1'b0;
        we_cnt = 0;
        en_cnt = 0;
    endtask

    task automatic clear_rom(input logic [15:0] fill);
        for (int i = 0; i < 4096; i++) rom[i] = fill;
    endtask

    task automatic model_step();
        logic [15:0] w;
        logic [3:0]  op;
        logic [1:0]  d;
        logic [1:0]  s;
        logic [15:0] k;
        logic [11:0] npc;
        w   = rom[mpc];
        op  = w[15:12];
        d   = w[11:10];
        s   = w[9:8];
        k   = {8'h00, w[7:0]};
        npc = mpc + 12'd1;
        mret = mret + 16'd1;
        if (op == 4'h0) mregs[d] = mregs[d] + mregs[s];
        else if (op == 4'h1) mregs[d] = mregs[d] - mregs[s];
        else if (op == 4'h2) mregs[d] = mregs[d] & mregs[s];
        else if (op == 4'h3) mregs[d] = mregs[d] | mregs[s];
        else if (op == 4'h4) mregs[d] = mregs[d] + k;
        else if (op == 4'h5) mregs[d] = mregs[d] & k;
        else if (op == 4'h8) npc = k[11:0];
        else if (op == 4'h9 && mregs[d] != 16'd0) npc = k[11:0];
        else if (op == 4'hF) begin
            mhalt = 1'b1;
            npc   = mpc;
        end
        mpc = npc;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:12] == 4'hF && $urandom_range(0, 9) != 0) w[15:12] = 4'h4;
        if (w[15:12] == 4'h8 || w[15:12] == 4'h9) w[7:0] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    initial begin
        logic [15:0] prev;
        logic [11:0] pc_hold;
        logic [15:0] ret_hold;
        int          retires;
        int          cyc;
        bit          first;

        n_cmp   = 0;
        n_bad   = 0;
        instr   = 16'h0000;
        rd_zero = 1'b0;
        for (int r = 0; r < 4; r++) regs[r] = 16'h0000;

        vecs[0]  = '{16'h4401, 16'h0001, 16'h0000, 12'h001, 16'h0002, 1, 1'b0};
        vecs[1]  = '{16'h1B00, 16'h0004, 16'h0002, 12'h001, 16'h0002, 1, 1'b0};
        vecs[2]  = '{16'h0100, 16'h0005, 16'h0007, 12'h001, 16'h000C, 1, 1'b0};
        vecs[3]  = '{16'h2600, 16'h0F0F, 16'h00FF, 12'h001, 16'h000F, 1, 1'b0};
        vecs[4]  = '{16'h3C00, 16'hF000, 16'h000F, 12'h001, 16'hF00F, 1, 1'b0};
        vecs[5]  = '{16'h500F, 16'h1234, 16'h1234, 12'h001, 16'h0004, 1, 1'b0};
        vecs[6]  = '{16'h8010, 16'h0009, 16'h0009, 12'h010, 16'h0009, 0, 1'b0};
        vecs[7]  = '{16'h9405, 16'h0001, 16'h0000, 12'h005, 16'h0001, 0, 1'b0};
        vecs[8]  = '{16'h9405, 16'h0000, 16'h0000, 12'h001, 16'h0000, 0, 1'b0};
        vecs[9]  = '{16'h6700, 16'h0003, 16'h0008, 12'h001, 16'h0003, 0, 1'b0};
        vecs[10] = '{16'hF000, 16'h0000, 16'h0000, 12'h000, 16'h0000, 0, 1'b1};
        vecs[11] = '{16'h0B00, 16'hFFFF, 16'h0002, 12'h001, 16'h0001, 1, 1'b0};
        vecs[12] = '{16'h1100, 16'h0000, 16'h0001, 12'h001, 16'hFFFF, 1, 1'b0};
        vecs[13] = '{16'h4CFF, 16'h0001, 16'h0000, 12'h001, 16'h0100, 1, 1'b0};

        // Reset state
        do_reset();
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_retired", 32'(retired), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_alu_op", 32'(alu_op), 32'h0);
        check("rst_alu_src_imm", 32'(alu_src_imm), 32'h0);
        en_in = 1'b1;
        #1;
        check("rst_idle_rom_en", 32'(rom_en), 32'h0);
        check("rst_idle_rf_we", 32'(rf_we), 32'h0);
        step();
        #1;
        check("first_fetch_rom_en", 32'(rom_en), 32'h1);

        // Single-instruction vectors from reset
        foreach (vecs[v]) begin
            clear_rom(16'h6000);
            rom[0] = vecs[v].ins;
            for (int r = 0; r < 4; r++) regs[r] = 16'h0000;
            regs[vecs[v].ins[9:8]]   = vecs[v].rs_init;
            regs[vecs[v].ins[11:10]] = vecs[v].rd_init;
            do_reset();
            en_in = 1'b1;
            for (int c = 0; c < 4; c++) step();
            check($sformatf("v%0d_retired_early", v), 32'(retired), 32'h0);
            step();
            en_in = 1'b0;
            check($sformatf("v%0d_pc", v), 32'(pc), 32'(vecs[v].exp_pc));
            check($sformatf("v%0d_retired", v), 32'(retired), 32'h1);
            check($sformatf("v%0d_rd", v), 32'(regs[vecs[v].ins[11:10]]), 32'(vecs[v].exp_rd));
            check($sformatf("v%0d_we_cnt", v), 32'(we_cnt), 32'(vecs[v].exp_we));
            check($sformatf("v%0d_halted", v), 32'(halted), 32'(vecs[v].exp_halt));
        end

        // ANDI x0 then SUB x2,x3
        clear_rom(16'h6000);
        rom[0] = 16'h5001;
        rom[1] = 16'h1B00;
        regs[0] = 16'h0000; regs[1] = 16'h0001; regs[2] = 16'h0004; regs[3] = 16'h0002;
        do_reset();
        en_in = 1'b1;
        for (int c = 0; c < 9; c++) step();
        en_in = 1'b0;
        check("seq2_x0", 32'(regs[0]), 32'h0);
        check("seq2_x2", 32'(regs[2]), 32'h2);
        check("seq2_retired", 32'(retired), 32'h2);
        check("seq2_pc", 32'(pc), 32'h2);
        check("seq2_we_cnt", 32'(we_cnt), 32'h2);

        // JMP 0x10 then HALT, then frozen
        clear_rom(16'h6000);
        rom[0]     = 16'h8010;
        rom[12'h10] = 16'hF000;
        do_reset();
        en_in = 1'b1;
        for (int c = 0; c < 5; c++) step();
        check("jmp_pc", 32'(pc), 32'h10);
        for (int c = 0; c < 4; c++) step();
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_pc", 32'(pc), 32'h10);
        check("halt_retired", 32'(retired), 32'h2);
        for (int c = 0; c < 20; c++) begin
            en_in = 1'($urandom_range(0, 1));
            step();
        end
        check("halt_frozen_pc", 32'(pc), 32'h10);
        check("halt_frozen_retired", 32'(retired), 32'h2);
        check("halt_frozen_halted", 32'(halted), 32'h1);
        check("halt_we_cnt", 32'(we_cnt), 32'h0);

        // en_in dropped for 3 cycles in EXEC of ADD x0,x1
        clear_rom(16'h6000);
        rom[0] = 16'h0100;
        regs[0] = 16'h0003; regs[1] = 16'h0004;
        do_reset();
        en_in = 1'b1;
        for (int c = 0; c < 3; c++) step();
        en_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_rf_we", 32'(rf_we), 32'h0);
        end
        check("stall_pc", 32'(pc), 32'h0);
        en_in = 1'b1;
        step();
        check("stall_retired_in_wb", 32'(retired), 32'h0);
        check("stall_we_before_wb", 32'(we_cnt), 32'h0);
        step();
        en_in = 1'b0;
        check("stall_retired", 32'(retired), 32'h1);
        check("stall_x0", 32'(regs[0]), 32'h7);
        check("stall_we_cnt", 32'(we_cnt), 32'h1);

        // rst asserted during WB
        clear_rom(16'h6000);
        rom[0] = 16'h0100;
        regs[0] = 16'h0003; regs[1] = 16'h0004;
        do_reset();
        en_in = 1'b1;
        for (int c = 0; c < 4; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("wbrst_pc", 32'(pc), 32'h0);
        check("wbrst_retired", 32'(retired), 32'h0);
        check("wbrst_rf_we", 32'(rf_we), 32'h0);
        check("wbrst_x0", 32'(regs[0]), 32'h3);
        check("wbrst_we_cnt", 32'(we_cnt), 32'h0);
        step();
        #1;
        check("wbrst_restart_fetch", 32'(rom_en), 32'h1);
        en_in = 1'b0;

        // PC wrap through a ROM of NOPs
        clear_rom(16'h6000);
        do_reset();
        en_in = 1'b1;
        step();
        for (int c = 0; c < 4095 * 4; c++) step();
        check("wrap_pc_fff", 32'(pc), 32'hFFF);
        for (int c = 0; c < 4; c++) step();
        en_in = 1'b0;
        check("wrap_pc_zero", 32'(pc), 32'h0);
        check("wrap_retired", 32'(retired), 32'd4096);

        // Random programs against the instruction-level interpreter
        for (int p = 0; p < 4; p++) begin
            clear_rom(16'h6000);
            for (int i = 0; i < 256; i++) rom[i] = rand_instr();
            for (int r = 0; r < 4; r++) begin
                regs[r]  = (p == 0 && r < 2) ? 16'h0000 : 16'($urandom);
                mregs[r] = regs[r];
            end
            do_reset();
            mpc     = 12'h000;
            mret    = 16'h0000;
            mhalt   = 1'b0;
            retires = 0;
            cyc     = 0;
            first   = 1'b1;
            while (retires < 80 && !mhalt && cyc < 3000) begin
                en_in = ($urandom_range(0, 4) != 0);
                prev  = retired;
                step();
                cyc++;
                if (retired !== prev) begin
                    model_step();
                    retires++;
                    check("rand_retired", 32'(retired), 32'(mret));
                    check("rand_pc", 32'(pc), 32'(mpc));
                    check("rand_halted", 32'(halted), 32'(mhalt));
                    for (int r = 0; r < 4; r++) check($sformatf("rand_x%0d", r), 32'(regs[r]), 32'(mregs[r]));
                    check("rand_cycles", 32'(en_cnt), first ? 32'd5 : 32'd4);
                    en_cnt = 0;
                    first  = 1'b0;
                end
            end
            if (!mhalt && retires < 80) check("rand_timeout", 32'(retires), 32'd80);
            pc_hold  = pc;
            ret_hold = retired;
            en_in = 1'b1;
            if (mhalt) begin
                for (int c = 0; c < 8; c++) step();
                check("rand_halt_pc", 32'(pc), 32'(pc_hold));
                check("rand_halt_retired", 32'(retired), 32'(ret_hold));
            end
            en_in = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
